// File: rtl/mnist_infer_ctrl.sv
// mnist_infer_ctrl: sequencer for the sigmoid fix4 inference engine.
// Takes one classify request, soft-resets and starts the engine, then waits for
// done under a timeout. It scans all class outputs, keeps the signed argmax, and
// returns class/score over a valid/ready handshake.
// Ports:
//   i_clk, i_rst_n              clock (rising edge), asynchronous active-low reset
//   i_req_valid / o_req_ready   request handshake; ready only while idle
//   o_res_valid / i_res_ready   result handshake
//   o_res_class, o_res_score    argmax index and its signed score (4'hF / 0 on timeout)
//   o_res_timeout               result is a timeout abort
//   o_busy                      controller not idle
//   o_img_count                 non-timeout results delivered, wraps
//   o_eng_reset, o_eng_start    one-cycle engine pulses
//   i_eng_done                  engine done level
//   o_eng_out_idx, i_eng_out    engine output select and the selected signed score
module mnist_infer_ctrl #(
    parameter int DATA_WIDTH     = 4,
    parameter int NUM_CLASSES    = 10,
    parameter int TO_WIDTH       = 20,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    output logic                         o_res_valid,
    input  logic                         i_res_ready,
    output logic [3:0]                   o_res_class,
    output logic signed [DATA_WIDTH-1:0] o_res_score,
    output logic                         o_res_timeout,
    output logic                         o_busy,
    output logic [CNT_WIDTH-1:0]         o_img_count,
    output logic                         o_eng_reset,
    output logic                         o_eng_start,
    input  logic                         i_eng_done,
    output logic [3:0]                   o_eng_out_idx,
    input  logic signed [DATA_WIDTH-1:0] i_eng_out
);
    typedef enum logic [2:0] {S_IDLE, S_CLR, S_GO, S_WAIT, S_SCAN, S_RESP} state_t;
    state_t                       r_state, w_next;
    logic [TO_WIDTH-1:0]          r_to_cnt;
    logic signed [DATA_WIDTH-1:0] r_best_val, w_best_val;
    logic [3:0]                   r_best_idx, w_best_idx, w_idx;
    logic                         w_take, w_to_hit, w_last;
    assign w_to_hit = r_to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1);
    assign w_last   = o_eng_out_idx == 4'(NUM_CLASSES - 1);
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_req_valid ? S_CLR : S_IDLE;
            S_CLR:   w_next = S_GO;
            S_GO:    w_next = S_WAIT;
            S_WAIT:  w_next = i_eng_done ? S_SCAN : (w_to_hit ? S_RESP : S_WAIT);
            S_SCAN:  w_next = w_last ? S_RESP : S_SCAN;
            S_RESP:  w_next = i_res_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end
    // Index 0 always loads; later indices replace only on a strictly greater
    // score, so ties keep the lowest index. o_eng_out_idx doubles as the scan index.
    always_comb begin
        w_take     = (o_eng_out_idx == 4'd0) || (i_eng_out > r_best_val);
        w_best_val = w_take ? i_eng_out : r_best_val;
        w_best_idx = w_take ? o_eng_out_idx : r_best_idx;
        w_idx      = (r_state == S_SCAN && w_next == S_SCAN) ? o_eng_out_idx + 4'd1 : 4'd0;
    end
    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_to_cnt      <= '0;
            r_best_val    <= '0;
            r_best_idx    <= 4'd0;
            o_req_ready   <= 1'b1;
            o_res_valid   <= 1'b0;
            o_res_class   <= 4'd0;
            o_res_score   <= '0;
            o_res_timeout <= 1'b0;
            o_busy        <= 1'b0;
            o_img_count   <= '0;
            o_eng_reset   <= 1'b0;
            o_eng_start   <= 1'b0;
            o_eng_out_idx <= 4'd0;
        end else begin
            r_state       <= w_next;
            r_to_cnt      <= (r_state == S_WAIT) ? r_to_cnt + TO_WIDTH'(1) : '0;
            o_req_ready   <= w_next == S_IDLE;
            o_busy        <= w_next != S_IDLE;
            o_res_valid   <= w_next == S_RESP;
            o_eng_reset   <= w_next == S_CLR;
            o_eng_start   <= w_next == S_GO;
            o_eng_out_idx <= w_idx;
            if (r_state == S_SCAN) begin
                r_best_val <= w_best_val;
                r_best_idx <= w_best_idx;
            end
            if (r_state == S_SCAN && w_next == S_RESP) begin
                o_res_class   <= w_best_idx;
                o_res_score   <= w_best_val;
                o_res_timeout <= 1'b0;
            end else if (r_state == S_WAIT && w_next == S_RESP) begin
                o_res_class   <= 4'hF;
                o_res_score   <= '0;
                o_res_timeout <= 1'b1;
            end
            if (r_state == S_RESP && i_res_ready && !o_res_timeout)
                o_img_count <= o_img_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_mnist_infer_ctrl.sv
// tb_mnist_infer_ctrl: randomized self-checking bench for mnist_infer_ctrl.
// A behavioural engine (score array + done delay) drives the main DUT; a second
// instance with a short timeout and a silent engine covers the abort path.
module tb_mnist_infer_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic              req_valid = 1'b0, res_ready = 1'b0, eng_done = 1'b0;
    logic              req_ready, res_valid, res_timeout, busy, eng_reset, eng_start;
    logic [3:0]        res_class, eng_out_idx;
    logic signed [3:0] res_score, eng_out;
    logic [15:0]       img_count;
    logic signed [3:0] outs [10];
    assign eng_out = (eng_out_idx < 4'd10) ? outs[eng_out_idx] : 4'sd0;
    logic              t_req_valid = 1'b0, t_res_ready = 1'b0;
    logic              t_req_ready, t_res_valid, t_res_timeout, t_busy, t_eng_reset, t_eng_start;
    logic [3:0]        t_res_class, t_eng_out_idx;
    logic signed [3:0] t_res_score;
    logic [15:0]       t_img_count;
    int                checks = 0, errors = 0;
    logic [15:0]       exp_cnt = 16'd0;

    mnist_infer_ctrl #(.TIMEOUT_CYCLES(200)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_class(res_class),
        .o_res_score(res_score), .o_res_timeout(res_timeout), .o_busy(busy),
        .o_img_count(img_count), .o_eng_reset(eng_reset), .o_eng_start(eng_start),
        .i_eng_done(eng_done), .o_eng_out_idx(eng_out_idx), .i_eng_out(eng_out));

    mnist_infer_ctrl #(.TIMEOUT_CYCLES(16)) dut_to (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(t_req_valid), .o_req_ready(t_req_ready),
        .o_res_valid(t_res_valid), .i_res_ready(t_res_ready), .o_res_class(t_res_class),
        .o_res_score(t_res_score), .o_res_timeout(t_res_timeout), .o_busy(t_busy),
        .o_img_count(t_img_count), .o_eng_reset(t_eng_reset), .o_eng_start(t_eng_start),
        .i_eng_done(1'b0), .o_eng_out_idx(t_eng_out_idx), .i_eng_out(4'sd0));

    // Reference: first index holding the maximum signed score.
    function automatic void ref_argmax(output logic [3:0] c, output logic signed [3:0] s);
        c = 4'd0;
        s = outs[0];
        for (int i = 1; i < 10; i++)
            if (outs[i] > s) begin
                s = outs[i];
                c = 4'(i);
            end
    endfunction

    task automatic set_outs(input int v [10]);
        for (int i = 0; i < 10; i++) outs[i] = 4'(v[i]);
    endtask

    task automatic accept();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1;
        @(posedge clk);
    endtask

    // One full image: done rises 'delay' cycles after the eng_start cycle, the
    // host holds res_ready low for 'hold' cycles. Cycle k counts from acceptance.
    task automatic run_img(input int delay, input int hold);
        logic [3:0]        ec;
        logic signed [3:0] es;
        int                kexp, ei;
        ref_argmax(ec, es);
        kexp = delay + 13;
        accept();
        for (int k = 1; k <= kexp; k++) begin
            @(negedge clk);
            if (k >= 3) eng_done = (k >= delay + 2);
            req_valid = (k % 3 == 0);
            ei = (k >= delay + 3 && k <= delay + 12) ? k - delay - 3 : 0;
            checks += 4;
            if ({eng_reset, eng_start} !== {k == 1, k == 2}) begin
                errors++;
                $display("FAIL pulses k=%0d: reset/start=%b%b", k, eng_reset, eng_start);
            end
            if (res_valid !== (k == kexp)) begin
                errors++;
                $display("FAIL res_valid_timing k=%0d: got %b expected at k=%0d", k, res_valid, kexp);
            end
            if (eng_out_idx !== 4'(ei)) begin
                errors++;
                $display("FAIL out_idx k=%0d: got %0d required %0d", k, eng_out_idx, ei);
            end
            if ({req_ready, busy} !== 2'b01) begin
                errors++;
                $display("FAIL busy k=%0d: req_ready=%b busy=%b", k, req_ready, busy);
            end
        end
        req_valid = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            checks++;
            if ({res_valid, res_timeout, req_ready, res_class, res_score} !== {3'b100, ec, es}) begin
                errors++;
                $display("FAIL result h=%0d: v=%b to=%b rdy=%b class=%0d score=%0d required class=%0d score=%0d",
                         h, res_valid, res_timeout, req_ready, res_class, res_score, ec, es);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_cnt++;
        checks++;
        if ({req_ready, res_valid, busy, img_count} !== {3'b100, exp_cnt}) begin
            errors++;
            $display("FAIL after_handshake: rdy=%b v=%b busy=%b count=%0d required count=%0d",
                     req_ready, res_valid, busy, img_count, exp_cnt);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({res_valid, res_timeout, busy, eng_reset, eng_start, req_ready, res_class, res_score, eng_out_idx, img_count}
            !== {6'b000001, 28'd0}) begin
            errors++;
            $display("FAIL reset_state: v=%b busy=%b rdy=%b class=%0d count=%0d", res_valid, busy, req_ready, res_class, img_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_argmax_example();
        set_outs('{-2, 1, 5, 3, 0, -8, 4, 2, 1, 7});
        run_img(50, 0);
    endtask

    task automatic test_tie();
        set_outs('{3, 7, 1, 7, 7, 0, 0, 0, 0, 0});
        run_img(4, 1);
    endtask

    task automatic test_negative();
        set_outs('{-8, -8, -8, -8, -8, -8, -8, -8, -8, -8});
        run_img(2, 0);
        set_outs('{-1, -1, -1, -1, -1, -3, -1, -1, -1, -1});
        run_img(1, 0);
    endtask

    task automatic test_timeout();
        @(negedge clk);
        t_req_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            t_req_valid = 1'b0;
            checks++;
            if ({t_res_valid, t_busy, t_eng_start} !== {k == 19, 1'b1, k == 2}) begin
                errors++;
                $display("FAIL timeout_timing k=%0d: v=%b busy=%b start=%b", k, t_res_valid, t_busy, t_eng_start);
            end
        end
        checks++;
        if ({t_res_timeout, t_res_class, t_res_score} !== {1'b1, 4'hF, 4'h0}) begin
            errors++;
            $display("FAIL timeout_result: to=%b class=%h score=%0d required 1/F/0", t_res_timeout, t_res_class, t_res_score);
        end
        t_res_ready = 1'b1;
        @(negedge clk);
        t_res_ready = 1'b0;
        checks++;
        if ({t_req_ready, t_res_valid, t_img_count} !== {2'b10, 16'd0}) begin
            errors++;
            $display("FAIL timeout_count: rdy=%b v=%b count=%0d required 0", t_req_ready, t_res_valid, t_img_count);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) outs[i] = 4'($urandom_range(0, 15));
        run_img(7, 20);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 10; i++) outs[i] = 4'($urandom_range(0, 15));
            run_img(int'($urandom_range(1, 40)), int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 10; i++) outs[i] = 4'($urandom_range(0, 15));
            run_img(1, 0);
        end
    endtask

    task automatic test_reset_mid();
        for (int pass = 0; pass < 2; pass++) begin
            int delay = (pass == 0) ? 30 : 5;
            int kabort = (pass == 0) ? 10 : 12;
            for (int i = 0; i < 10; i++) outs[i] = 4'($urandom_range(0, 15));
            accept();
            for (int k = 1; k <= kabort; k++) begin
                @(negedge clk);
                req_valid = 1'b0;
                if (k >= 3) eng_done = (k >= delay + 2);
            end
            if (pass == 1) begin
                checks++;
                if (eng_out_idx !== 4'd4) begin
                    errors++;
                    $display("FAIL scan_idx4: got %0d required 4", eng_out_idx);
                end
            end
            #2 rst_n = 1'b0;
            #1;
            exp_cnt = 16'd0;
            checks++;
            if ({res_valid, res_timeout, busy, eng_reset, eng_start, req_ready, res_class, res_score, eng_out_idx, img_count}
                !== {6'b000001, 28'd0}) begin
                errors++;
                $display("FAIL mid_reset pass=%0d: v=%b busy=%b rdy=%b idx=%0d count=%0d",
                         pass, res_valid, busy, req_ready, eng_out_idx, img_count);
            end
            eng_done = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 10; i++) outs[i] = 4'($urandom_range(0, 15));
            run_img(3, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 10; i++) outs[i] = 4'sd0;
        test_reset();
        test_argmax_example();
        test_tie();
        test_negative();
        test_timeout();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
